// File: rtl/multi_counter_variants_pkg.sv
// Shared definitions for the multi-counter command interface.
//
// Contents:
//   op_t          - 5-bit command opcode. Bit OP_WRITE_B marks the write-class
//                   ops (INIT/INCR/DECR), which modify a counter.
//   OP_*_B        - bit positions inside the opcode.
//   is_legal_op() - true for the opcodes the array understands.
//   id_w()        - counter-id width for a given number of counters (min 1).
`timescale 1ns/1ps
package multi_counter_variants_pkg;

    localparam int OP_QRY_B   = 0;
    localparam int OP_INIT_B  = 1;
    localparam int OP_INCR_B  = 2;
    localparam int OP_DECR_B  = 3;
    localparam int OP_WRITE_B = 4;

    typedef enum logic [4:0] {
        OP_NOP  = 5'b00000,
        OP_QRY  = 5'b00001,
        OP_INIT = 5'b10010,
        OP_INCR = 5'b10100,
        OP_DECR = 5'b11000
    } op_t;

    function automatic logic is_legal_op(op_t op);
        case (op)
            OP_NOP, OP_QRY, OP_INIT, OP_INCR, OP_DECR: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    function automatic int id_w(int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_counter_rsp_fifo.sv
// Small synchronous FIFO with show-ahead read (rd_data is the current head).
// Used by the issuer both as the outstanding-query id FIFO and as the
// response return buffer. There is no overflow/underflow protection: the
// caller's credit accounting keeps push/pop legal.
//
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset (empties the FIFO)
//   push, wr_data   - write one entry
//   pop             - drop the head entry
//   rd_data         - head entry (undefined while empty)
//   full, empty     - occupancy flags
`timescale 1ns/1ps
module multi_counter_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_reg[AW-1:0]];
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/multi_counter_cmd_issuer.sv
// Initiator front end for the multi-counter array.
//
// Host requests (req_*) are accepted on req_vld & req_rdy and re-issued one
// cycle later as single-cycle commands on cmd_*. Queries consume a credit and
// push their id into an id FIFO; each rsp_pass from the array pops that FIFO
// and stores {id, data} in the return buffer, which is drained to the host on
// out_vld & out_rdy (returning the credit). Responses stay in issue order.
//
// Ports:
//   clk, rst_n                        - clock, synchronous active-low reset
//   req_vld/req_op/req_id/req_dat     - host request, req_rdy = accepted
//   cmd_pass/cmd_op/cmd_id/cmd_dat    - registered command to the array
//   rsp_pass/rsp_dat                  - query response (never stalled)
//   out_vld/out_id/out_dat/out_rdy    - host response with backpressure
//   err_illegal                       - sticky, set by an unknown opcode
//
// Build option MULTI_COUNTER_CMD_ISSUER_HAZARD_EN: stall a query whose id
// matches a write-class command issued in the last PIPE_LAT cycles.
`timescale 1ns/1ps
module multi_counter_cmd_issuer
    import multi_counter_variants_pkg::*;
#(
    parameter int CNTRS_N   = 16,
    parameter int CNTR_W    = 32,
    parameter int RSP_DEPTH = 4,
    parameter int PIPE_LAT  = 2,
    localparam int ID_W     = id_w(CNTRS_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_vld,
    input  logic [4:0]        req_op,
    input  logic [ID_W-1:0]   req_id,
    input  logic [CNTR_W-1:0] req_dat,
    output logic              req_rdy,
    output logic              cmd_pass,
    output logic [4:0]        cmd_op,
    output logic [ID_W-1:0]   cmd_id,
    output logic [CNTR_W-1:0] cmd_dat,
    input  logic              rsp_pass,
    input  logic [CNTR_W-1:0] rsp_dat,
    output logic              out_vld,
    output logic [ID_W-1:0]   out_id,
    output logic [CNTR_W-1:0] out_dat,
    input  logic              out_rdy,
    output logic              err_illegal
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] CREDITS_MAX = CW'(RSP_DEPTH);
    localparam logic [CW-1:0] CREDIT_ONE  = CW'(1);

    logic              req_legal;
    logic              req_is_qry;
    logic              qry_hazard;
    logic              accept;
    logic              issue;
    logic              qry_push;
    logic              rsp_take;
    logic              ret_pop;
    logic [CW-1:0]     credits_reg;
    logic [CW-1:0]     credits_next;
    logic              id_full;
    logic              id_empty;
    logic [ID_W-1:0]   id_head;
    logic              ret_full;
    logic              ret_empty;
    logic [ID_W+CNTR_W-1:0] ret_head;

    assign req_legal  = is_legal_op(op_t'(req_op));
    assign req_is_qry = (req_op == OP_QRY);

    // Readiness depends only on the head request: non-queries always go,
    // a query needs a credit (and no pending write hazard when enabled).
    assign req_rdy  = rst_n & (~req_is_qry |
                      ((credits_reg != '0) & ~id_full & ~qry_hazard));
    assign accept   = req_vld & req_rdy;
    assign issue    = accept & req_legal & (req_op != OP_NOP);
    assign qry_push = accept & req_is_qry;

    // A response with nothing outstanding is a protocol error and is dropped;
    // this also discards stale responses arriving right after reset.
    assign rsp_take = rsp_pass & ~id_empty & ~ret_full;
    assign ret_pop  = ~ret_empty & out_rdy;

    always_comb begin
        credits_next = credits_reg;
        if (qry_push && !ret_pop) begin
            credits_next = credits_reg - CREDIT_ONE;
        end else if (ret_pop && !qry_push && credits_reg != CREDITS_MAX) begin
            credits_next = credits_reg + CREDIT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_pass    <= 1'b0;
            cmd_op      <= OP_NOP;
            cmd_id      <= '0;
            cmd_dat     <= '0;
            err_illegal <= 1'b0;
            credits_reg <= CREDITS_MAX;
        end else begin
            cmd_pass    <= issue;
            credits_reg <= credits_next;
            if (issue) begin
                cmd_op  <= req_op;
                cmd_id  <= req_id;
                cmd_dat <= req_dat;
            end else begin
                cmd_op  <= OP_NOP;
            end
            if (accept && !req_legal) begin
                err_illegal <= 1'b1;
            end
        end
    end

    multi_counter_rsp_fifo #(
        .WIDTH (ID_W),
        .DEPTH (RSP_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (qry_push),
        .wr_data (req_id),
        .pop     (rsp_take),
        .rd_data (id_head),
        .full    (id_full),
        .empty   (id_empty)
    );

    multi_counter_rsp_fifo #(
        .WIDTH (ID_W + CNTR_W),
        .DEPTH (RSP_DEPTH)
    ) u_ret_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (rsp_take),
        .wr_data ({id_head, rsp_dat}),
        .pop     (ret_pop),
        .rd_data (ret_head),
        .full    (ret_full),
        .empty   (ret_empty)
    );

    // Force zeros while empty so the host never sees stale buffer contents.
    assign out_vld = ~ret_empty;
    assign out_id  = ret_empty ? '0 : ret_head[ID_W+CNTR_W-1:CNTR_W];
    assign out_dat = ret_empty ? '0 : ret_head[CNTR_W-1:0];

`ifdef MULTI_COUNTER_CMD_ISSUER_HAZARD_EN
    // Age pipeline of issued write-class commands; an entry retires once the
    // array has made the update visible.
    logic [PIPE_LAT-1:0] haz_vld_reg;
    logic [ID_W-1:0]     haz_id_reg [PIPE_LAT];
    logic [PIPE_LAT-1:0] haz_hit;
    logic                wr_issue;

    assign wr_issue = issue & req_op[OP_WRITE_B];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            haz_vld_reg <= '0;
        end else begin
            haz_vld_reg[0] <= wr_issue;
            for (int i = 1; i < PIPE_LAT; i++) begin
                haz_vld_reg[i] <= haz_vld_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        haz_id_reg[0] <= req_id;
        for (int i = 1; i < PIPE_LAT; i++) begin
            haz_id_reg[i] <= haz_id_reg[i-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_haz
            assign haz_hit[gi] = haz_vld_reg[gi] && (haz_id_reg[gi] == req_id);
        end
    endgenerate

    assign qry_hazard = |haz_hit;
`else
    assign qry_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_multi_counter_cmd_issuer.sv
`timescale 1ns/1ps
module tb_multi_counter_cmd_issuer;
    import multi_counter_variants_pkg::*;

    localparam int CNTRS_N   = 16;
    localparam int CNTR_W    = 32;
    localparam int RSP_DEPTH = 4;
    localparam int PIPE_LAT  = 2;
    localparam int ID_W      = 4;
`ifdef MULTI_COUNTER_CMD_ISSUER_HAZARD_EN
    localparam int HAZ_STALL = 2;
`else
    localparam int HAZ_STALL = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_vld;
    logic [4:0]        req_op;
    logic [ID_W-1:0]   req_id;
    logic [CNTR_W-1:0] req_dat;
    logic              req_rdy;
    logic              cmd_pass;
    logic [4:0]        cmd_op;
    logic [ID_W-1:0]   cmd_id;
    logic [CNTR_W-1:0] cmd_dat;
    logic              rsp_pass = 1'b0;
    logic [CNTR_W-1:0] rsp_dat  = '0;
    logic              out_vld;
    logic [ID_W-1:0]   out_id;
    logic [CNTR_W-1:0] out_dat;
    logic              out_rdy;
    logic              err_illegal;

    multi_counter_cmd_issuer #(
        .CNTRS_N   (CNTRS_N),
        .CNTR_W    (CNTR_W),
        .RSP_DEPTH (RSP_DEPTH),
        .PIPE_LAT  (PIPE_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_vld     (req_vld),
        .req_op      (req_op),
        .req_id      (req_id),
        .req_dat     (req_dat),
        .req_rdy     (req_rdy),
        .cmd_pass    (cmd_pass),
        .cmd_op      (cmd_op),
        .cmd_id      (cmd_id),
        .cmd_dat     (cmd_dat),
        .rsp_pass    (rsp_pass),
        .rsp_dat     (rsp_dat),
        .out_vld     (out_vld),
        .out_id      (out_id),
        .out_dat     (out_dat),
        .out_rdy     (out_rdy),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]        op;
        logic [ID_W-1:0]   id;
        logic [CNTR_W-1:0] dat;
        int                acc;
    } cmd_exp_t;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [CNTR_W-1:0] dat;
    } rsp_exp_t;

    typedef struct {
        logic [CNTR_W-1:0] dat;
        int                due;
    } pend_t;

    cmd_exp_t exp_cmd[$];
    rsp_exp_t exp_rsp[$];
    cmd_exp_t mon_ce;
    rsp_exp_t mon_re;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_cmd.delete();
            exp_rsp.delete();
        end else begin
            if (cmd_pass) begin
                if (exp_cmd.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_cmd: got op=%b id=%0d, required no command", cmd_op, cmd_id);
                end else begin
                    mon_ce = exp_cmd.pop_front();
                    chk("cmd_op_id", {cmd_op, cmd_id}, {mon_ce.op, mon_ce.id});
                    chk("cmd_latency_cycle", cyc, mon_ce.acc + 1);
                    if (mon_ce.op == OP_INIT) chk("cmd_dat", cmd_dat, mon_ce.dat);
                end
            end
            if (out_vld && out_rdy) begin
                if (exp_rsp.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got id=%0d dat=0x%0h, required no response", out_id, out_dat);
                end else begin
                    mon_re = exp_rsp.pop_front();
                    chk("rsp_id_dat", {out_id, out_dat}, {mon_re.id, mon_re.dat});
                end
            end
        end
    end

    // ---------------- counter array stub ----------------
    logic [CNTR_W-1:0] mdl_cnt [CNTRS_N] = '{default: '0};
    pend_t pend[$];
    int stale_at_cyc = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
        end else if (cmd_pass) begin
            case (op_t'(cmd_op))
                OP_INIT: mdl_cnt[cmd_id] = cmd_dat;
                OP_INCR: mdl_cnt[cmd_id] = mdl_cnt[cmd_id] + 1;
                OP_DECR: mdl_cnt[cmd_id] = mdl_cnt[cmd_id] - 1;
                OP_QRY:  pend.push_back('{mdl_cnt[cmd_id], cyc + 2});
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        rsp_pass = 1'b0;
        rsp_dat  = '0;
        if (cyc == stale_at_cyc) begin
            rsp_pass = 1'b1;
            rsp_dat  = 32'hDEAD_BEEF;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            rsp_pass = 1'b1;
            rsp_dat  = pend[0].dat;
            void'(pend.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    // w = number of cycles the request waited with req_rdy low.
    task automatic send(input logic [4:0] op, input logic [ID_W-1:0] id,
                        input logic [CNTR_W-1:0] dat, input logic [CNTR_W-1:0] rdat,
                        output int w);
        req_vld = 1'b1;
        req_op  = op;
        req_id  = id;
        req_dat = dat;
        w = 0;
        @(negedge clk);
        while (!req_rdy && w < 40) begin
            w++;
            @(negedge clk);
        end
        if (!req_rdy) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: op=%b id=%0d not accepted, required acceptance within 40 cycles", op, id);
            req_vld = 1'b0;
        end else begin
            if (op == OP_QRY || op == OP_INIT || op == OP_INCR || op == OP_DECR)
                exp_cmd.push_back('{op, id, dat, cyc});
            if (op == OP_QRY)
                exp_rsp.push_back('{id, rdat});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_vld = 1'b0;
        req_op  = OP_NOP;
        req_id  = '0;
        req_dat = '0;
    endtask

    task automatic wait_drain(input int max);
        int k = 0;
        while ((exp_cmd.size() != 0 || exp_rsp.size() != 0) && k < max) begin
            @(negedge clk);
            k++;
        end
        if (exp_cmd.size() != 0 || exp_rsp.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d cmds and %0d rsps outstanding, required 0",
                     exp_cmd.size(), exp_rsp.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int w;
        int seen;

        rst_n   = 1'b0;
        out_rdy = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        // Reset values, with a query presented to show req_rdy is held low.
        req_vld = 1'b1;
        req_op  = OP_QRY;
        @(negedge clk);
        chk("rst_req_rdy",  req_rdy, 0);
        chk("rst_cmd_pass", cmd_pass, 0);
        chk("rst_cmd_op",   cmd_op, OP_NOP);
        chk("rst_cmd_id",   cmd_id, 0);
        chk("rst_cmd_dat",  cmd_dat, 0);
        chk("rst_out_vld",  out_vld, 0);
        chk("rst_out_id",   out_id, 0);
        chk("rst_out_dat",  out_dat, 0);
        chk("rst_err",      err_illegal, 0);
        @(posedge clk);
        #1;
        idle();
        rst_n   = 1'b1;
        out_rdy = 1'b1;

        // T1: INIT / INCR / QRY to id3 -> 0x11
        send(OP_INIT, 4'd3, 32'h10, 0, w);
        chk("t1_init_wait", w, 0);
        send(OP_INCR, 4'd3, 0, 0, w);
        chk("t1_incr_wait", w, 0);
        send(OP_QRY, 4'd3, 0, 32'h11, w);
        chk("t1_qry_wait", w, HAZ_STALL);
        idle();
        wait_drain(50);

        // Known values: counter i = 0x20 + i
        for (int i = 0; i < 8; i++) send(OP_INIT, 4'(i), 32'h20 + i, 0, w);
        idle();
        wait_drain(50);

        // T2: credit exhaustion with the host stalled
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(OP_QRY, 4'(i), 0, 32'h20 + i, w);
            chk("t2_qry_with_credit", w, 0);
        end
        send(OP_INCR, 4'd7, 0, 0, w);
        chk("t2_incr_at_zero_credit", w, 0);
        fork
            send(OP_QRY, 4'd4, 0, 32'h24, w);
            begin
                repeat (4) @(posedge clk);
                #1 out_rdy = 1'b1;
                @(posedge clk);
                #1 out_rdy = 1'b0;
            end
        join
        chk("t2_fifth_qry_wait", w, 5);
        idle();
        out_rdy = 1'b1;
        wait_drain(60);

        // T3: simultaneous issue and pop at credits=1, 8 queries in order
        out_rdy = 1'b0;
        send(OP_QRY, 4'd0, 0, 32'h20, w);
        send(OP_QRY, 4'd1, 0, 32'h21, w);
        send(OP_QRY, 4'd2, 0, 32'h22, w);
        idle();
        repeat (6) @(posedge clk);
        #1;
        out_rdy = 1'b1;
        send(OP_QRY, 4'd3, 0, 32'h23, w);
        chk("t3_qry_with_pop_wait", w, 0);
        send(OP_QRY, 4'd4, 0, 32'h24, w);
        chk("t3_credit_kept_wait", w, 0);
        send(OP_QRY, 4'd5, 0, 32'h25, w);
        send(OP_QRY, 4'd6, 0, 32'h26, w);
        send(OP_QRY, 4'd7, 0, 32'h28, w);
        idle();
        wait_drain(80);

        // T4: illegal opcode and NOP
        send(5'b11111, 4'd2, 0, 0, w);
        chk("t4_illegal_wait", w, 0);
        idle();
        @(negedge clk);
        chk("t4_illegal_no_cmd", cmd_pass, 0);
        chk("t4_err_set", err_illegal, 1);
        @(posedge clk);
        #1;
        send(OP_NOP, 4'd1, 0, 0, w);
        chk("t4_nop_wait", w, 0);
        idle();
        repeat (5) @(posedge clk);
        #1;
        chk("t4_err_sticky", err_illegal, 1);
        wait_drain(10);

        // T5: read-after-write hazard
        send(OP_INCR, 4'd5, 0, 0, w);
        send(OP_QRY, 4'd5, 0, 32'h26, w);
        chk("t5_raw_same_id_wait", w, HAZ_STALL);
        send(OP_INCR, 4'd5, 0, 0, w);
        send(OP_QRY, 4'd6, 0, 32'h26, w);
        chk("t5_other_id_wait", w, 0);
        idle();
        wait_drain(50);

        // T6: reset with queries outstanding
        out_rdy = 1'b0;
        send(OP_QRY, 4'd0, 0, 32'h20, w);
        send(OP_QRY, 4'd1, 0, 32'h21, w);
        send(OP_QRY, 4'd2, 0, 32'h22, w);
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        stale_at_cyc = cyc + 2;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_out_vld", out_vld, 0);
        chk("t6_rst_req_rdy", req_rdy, 0);
        chk("t6_rst_err_cleared", err_illegal, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_vld) seen = 1;
        end
        chk("t6_stale_rsp_ignored", seen, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            send(OP_QRY, 4'(i), 0, 32'h20 + i, w);
            chk("t6_credit_restored_wait", w, 0);
        end
        req_vld = 1'b1;
        req_op  = OP_QRY;
        req_id  = 4'd4;
        @(negedge clk);
        chk("t6_credits_exhausted", req_rdy, 0);
        @(posedge clk);
        #1;
        idle();
        out_rdy = 1'b1;
        wait_drain(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_counter_cmd_issuer.md
Name: multi_counter_cmd_issuer

Overview:
Initiator-side front end for the multi-counter array. It accepts host requests over a valid/ready interface and issues single-cycle op_t commands (NOP/INIT/INCR/DECR/QRY) to the counter array. It collects in-order query responses into a credit-managed return buffer and presents them to the host with backpressure. It is the issuing end of the op_t command interface; the counter array is the responder.

Parameters:
CNTRS_N, 16, number of counters addressed; id width = $clog2(CNTRS_N)
CNTR_W, 32, counter/data width
RSP_DEPTH, 4, return buffer entries = max outstanding QRY (power of 2, >=2)
PIPE_LAT, 2, cycles from write-class command issue to the counter update being visible (used by the hazard option)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_vld  in  1  host request valid
req_op  in  5  host op (op_t)
req_id  in  $clog2(CNTRS_N)  target counter
req_dat  in  CNTR_W  INIT value
req_rdy  out  1  request accepted when req_vld & req_rdy
cmd_pass  out  1  command strobe to array
cmd_op  out  5  op_t to array
cmd_id  out  $clog2(CNTRS_N)  counter id
cmd_dat  out  CNTR_W  INIT data
rsp_pass  in  1  query response from array (cannot be stalled)
rsp_dat  in  CNTR_W  query response data
out_vld  out  1  host response valid
out_id  out  $clog2(CNTRS_N)  id of returned query
out_dat  out  CNTR_W  returned count
out_rdy  in  1  host response ready
err_illegal  out  1  sticky: unrecognised op code received

Behaviour:
- Reset (rst_n=0 at posedge): req_rdy=0 during reset; cmd_pass=0, cmd_op=OP_NOP, cmd_id=0, cmd_dat=0; out_vld=0, out_id=0, out_dat=0; err_illegal=0; credits=RSP_DEPTH; id FIFO and return buffer empty. Reset mid-operation discards all in-flight queries; rsp_pass arriving in the 1st cycle after reset release is ignored.
- Command path is registered: accepted request appears on cmd_* the following cycle with cmd_pass=1; otherwise cmd_pass=0, cmd_op=OP_NOP.
- OP_NOP request: accepted, consumed, no cmd_pass.
- Illegal op (not in op_t): accepted, dropped, err_illegal set until reset.
- QRY issue requires credits>0; issuing pushes req_id into id FIFO and decrements credits. credits==0 -> req_rdy=0 for QRY only; INIT/INCR/DECR still accepted (req_rdy is a function of the head request; no reordering).
- rsp_pass: pops id FIFO head, writes {id,rsp_dat} into return buffer. rsp_pass with empty id FIFO is a protocol error: ignored (assertion in bench).
- Host return: out_* = buffer head; pop on out_vld & out_rdy, credits+1 same cycle. Simultaneous QRY issue and host pop: credits unchanged. Credits never exceed RSP_DEPTH.
- Ordering: responses returned strictly in issue order; throughput 1 command/cycle, 1 response/cycle.
- Counter arithmetic (wrap/saturate) belongs to the array; the issuer never modifies data.

Optional Feature:
MULTI_COUNTER_CMD_ISSUER_HAZARD_EN
- Defined: issuer holds a PIPE_LAT-deep shift register of {valid,id} for issued write-class ops (op bit OP_WRITE_B set). A QRY whose req_id matches any valid entry is stalled (req_rdy=0) until the entry retires, guaranteeing the query observes all prior writes. Write-after-write is not stalled.
- Undefined: no hazard tracking; QRY issues back-to-back after INCR to same id; array is responsible for forwarding.

Decomposition:
- Shared package (multi_counter_variants_pkg): op_t, OP_*_B bit positions, plus new function is_legal_op(op_t) and localparam ID_W derivation helper.
- One sub-module: multi_counter_rsp_fifo — parameterised sync FIFO (width, depth), used for both id FIFO and return buffer; full/empty flags, no overflow protection (credit logic guarantees).

Test Plan:
- Reset then INIT id3 dat 0x10, INCR id3, QRY id3 -> cmd stream INIT/INCR/QRY on consecutive cycles; array model returns 0x11 -> out_id=3, out_dat=0x11.
- RSP_DEPTH=4, out_rdy=0, issue 5 QRY -> 4 issued, req_rdy=0 on 5th; raise out_rdy for 1 cycle -> 5th issues next cycle; INCR behind it blocked, INCR queued before accepted.
- Simultaneous QRY issue and out pop at credits=1 -> credits stay 1, no deadlock; all 8 of 8 responses return in order with correct ids.
- req_op=5'b1_11_11 -> no cmd_pass, err_illegal=1 and stays 1 until rst_n=0.
- HAZARD_EN, PIPE_LAT=2: INCR id5 then QRY id5 -> QRY stalls 2 cycles; QRY id6 right after INCR id5 -> no stall.
- Assert rst_n=0 with 3 QRY outstanding -> out_vld=0, credits=4; stale rsp_pass after reset produces no output.
